rom_burst_reader: RTL and testbench

ROM_BURST_READER -- requirements
Module: rom_burst_reader

---
 rtl/rom_burst_reader_if.sv | 21 ++
 rtl/rom_burst_reader.sv | 143 ++++++++++++++
 tb/tb_rom_burst_reader.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_burst_reader_if.sv
// ROM read port between the burst reader (master) and the ROM (slave).
interface rom_burst_reader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd_en;
    logic [DATA_W-1:0] rom_q;

    modport master (
        output rom_addr,
        output rom_rd_en,
        input  rom_q
    );

    modport slave (
        input  rom_addr,
        input  rom_rd_en,
        output rom_q
    );
endinterface

// File: rtl/rom_burst_reader.sv
// Issues a burst of ROM reads and captures the returned words into a buffer.
module rom_burst_reader #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 6,
    parameter int MAX_LEN = 32,
    parameter int RD_LAT  = 1,
    localparam int CW = $clog2(MAX_LEN + 1),
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [CW-1:0]             length,
    input  logic                      abort,
    rom_burst_reader_if.master        rom,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [CW-1:0]             word_count,
    output logic                      word_valid,
    output logic [IW-1:0]             word_idx,
    output logic [DATA_W-1:0]         word_data,
    output logic [MAX_LEN*DATA_W-1:0] buf_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [CW-1:0] MAX_L = CW'(MAX_LEN);

    state_t state;
    state_t state_next;

    logic [IW-1:0]     req_idx;
    logic [IW-1:0]     last_idx;
    logic              tag_v [RD_LAT];
    logic [IW-1:0]     tag_i [RD_LAT];
    logic [DATA_W-1:0] mem [MAX_LEN];

    logic accept;
    logic len_ok;
    logic kill;
    logic cap;
    logic last_req;
    logic in_flight;

    assign busy = (state == ISSUE) || (state == DRAIN);
    assign done = (state == DONE);

    for (genvar k = 0; k < MAX_LEN; k++) begin : g_pack
        assign buf_data[k*DATA_W +: DATA_W] = mem[k];
    end

    always_comb begin
        accept    = start && ((state == IDLE) || (state == DONE));
        len_ok    = (length != '0) && (length <= MAX_L);
        kill      = abort && busy;
        cap       = tag_v[RD_LAT-1] && !kill;
        last_req  = (state == ISSUE) && (req_idx == last_idx);
        // Anything still in flight besides the word captured this cycle
        in_flight = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            in_flight = in_flight | tag_v[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) state_next = len_ok ? ISSUE : DONE;
            end
            ISSUE: begin
                if (kill)          state_next = DONE;
                else if (last_req) state_next = DRAIN;
            end
            DRAIN: begin
                if (kill || !in_flight) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom.rom_addr  <= '0;
            rom.rom_rd_en <= 1'b0;
            req_idx       <= '0;
            last_idx      <= '0;
            err           <= 1'b0;
            word_count    <= '0;
            word_valid    <= 1'b0;
            word_idx      <= '0;
            word_data     <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_v[i] <= 1'b0;
                tag_i[i] <= '0;
            end
            for (int k = 0; k < MAX_LEN; k++) begin
                mem[k] <= '0;
            end
        end else begin
            word_valid <= 1'b0;
            tag_v[0]   <= rom.rom_rd_en && !kill;
            tag_i[0]   <= req_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1] && !kill;
                tag_i[i] <= tag_i[i-1];
            end

            if (cap) begin
                mem[tag_i[RD_LAT-1]] <= rom.rom_q;
                word_count <= word_count + 1'b1;
                word_valid <= 1'b1;
                word_idx   <= tag_i[RD_LAT-1];
                word_data  <= rom.rom_q;
            end

            if (accept) begin
                rom.rom_addr  <= base_addr;
                rom.rom_rd_en <= len_ok;
                req_idx       <= '0;
                last_idx      <= IW'(length - 1'b1);
                word_count    <= '0;
                err           <= !len_ok;
            end else if (kill) begin
                rom.rom_rd_en <= 1'b0;
                err           <= 1'b1;
            end else if (last_req) begin
                rom.rom_rd_en <= 1'b0;
            end else if (state == ISSUE) begin
                rom.rom_addr <= rom.rom_addr + 1'b1;
                req_idx      <= req_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Scoreboard bench: two readers (read latency 1 and 3) share one stimulus stream.
module tb_rom_burst_reader;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int ML = 32;
    localparam int CW = 6;
    localparam int IW = 5;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } word_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] length;

    always #5 clk = ~clk;

    rom_burst_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
    rom_burst_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus3 ();

    logic             busy1, done1, err1, wv1;
    logic [CW-1:0]    wc1;
    logic [IW-1:0]    widx1;
    logic [DW-1:0]    wd1;
    logic [ML*DW-1:0] buf1;
    logic             busy3, done3, err3, wv3;
    logic [CW-1:0]    wc3;
    logic [IW-1:0]    widx3;
    logic [DW-1:0]    wd3;
    logic [ML*DW-1:0] buf3;

    rom_burst_reader #(.DATA_W(DW), .ADDR_W(AW), .MAX_LEN(ML), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .abort(abort), .rom(bus1), .busy(busy1),
        .done(done1), .err(err1), .word_count(wc1), .word_valid(wv1),
        .word_idx(widx1), .word_data(wd1), .buf_data(buf1)
    );

    rom_burst_reader #(.DATA_W(DW), .ADDR_W(AW), .MAX_LEN(ML), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .abort(abort), .rom(bus3), .busy(busy3),
        .done(done3), .err(err3), .word_count(wc3), .word_valid(wv3),
        .word_idx(widx3), .word_data(wd3), .buf_data(buf3)
    );

    // ROM models: q = addr ^ A5 after the latency, junk when no read was made
    logic [AW-1:0] ra1;
    logic          re1;
    logic [AW-1:0] ra3 [3];
    logic          re3 [3];
    logic [DW-1:0] junk;

    always @(posedge clk) begin
        ra1    <= bus1.rom_addr;
        re1    <= bus1.rom_rd_en;
        ra3[0] <= bus3.rom_addr;
        re3[0] <= bus3.rom_rd_en;
        ra3[1] <= ra3[0];
        re3[1] <= re3[0];
        ra3[2] <= ra3[1];
        re3[2] <= re3[1];
        junk   <= DW'($urandom);
    end

    assign bus1.rom_q = re1    ? ({2'b00, ra1} ^ 8'hA5)    : junk;
    assign bus3.rom_q = re3[2] ? ({2'b00, ra3[2]} ^ 8'hA5) : junk;

    int            cyc = 0;
    int            checks = 0;
    int            passes = 0;
    bit            active = 1'b0;
    int            t0 [2];
    int            exp_done [2];
    int            exp_cnt [2];
    bit            exp_err [2];
    logic [DW-1:0] mbuf [2][ML];
    logic [AW-1:0] aq0 [$];
    logic [AW-1:0] aq1 [$];
    word_t         wq0 [$];
    word_t         wq1 [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    task automatic chk_buf(input string name, input logic [ML*DW-1:0] act,
                           input logic [ML*DW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic bit pop_addr(input int d, output logic [AW-1:0] a);
        a = '0;
        if (d == 0) begin
            if (aq0.size() == 0) return 1'b0;
            a = aq0.pop_front();
        end else begin
            if (aq1.size() == 0) return 1'b0;
            a = aq1.pop_front();
        end
        return 1'b1;
    endfunction

    function automatic bit pop_word(input int d, output word_t w);
        w = '0;
        if (d == 0) begin
            if (wq0.size() == 0) return 1'b0;
            w = wq0.pop_front();
        end else begin
            if (wq1.size() == 0) return 1'b0;
            w = wq1.pop_front();
        end
        return 1'b1;
    endfunction

    task automatic mon(input int d, input logic en, input logic [AW-1:0] a,
                       input logic wv, input logic [IW-1:0] wi,
                       input logic [DW-1:0] wdat, input logic dn,
                       input logic er, input logic [CW-1:0] wc);
        string         p;
        word_t         w;
        logic [AW-1:0] ea;
        p = (d == 0) ? "L1" : "L3";
        if (!active) return;
        if (en) begin
            if (pop_addr(d, ea)) chk({p, " rom_addr"}, 64'(a), 64'(ea));
            else chk({p, " extra_req"}, 64'(en), 64'(0));
        end
        if (wv) begin
            if (pop_word(d, w)) begin
                chk({p, " word_idx"}, 64'(wi), 64'(w.idx));
                chk({p, " word_data"}, 64'(wdat), 64'(w.data));
            end else begin
                chk({p, " extra_word"}, 64'(wv), 64'(0));
            end
        end
        if (exp_done[d] > 0) begin
            if (cyc > t0[d] && cyc < exp_done[d])
                chk({p, " done_early"}, 64'(dn), 64'(0));
            if (cyc == exp_done[d]) begin
                chk({p, " done"}, 64'(dn), 64'(1));
                chk({p, " err"}, 64'(er), 64'(exp_err[d]));
                chk({p, " word_count"}, 64'(wc), 64'(exp_cnt[d]));
            end
        end
    endtask

    always @(negedge clk)
        mon(0, bus1.rom_rd_en, bus1.rom_addr, wv1, widx1, wd1, done1, err1, wc1);
    always @(negedge clk)
        mon(1, bus3.rom_rd_en, bus3.rom_addr, wv3, widx3, wd3, done3, err3, wc3);

    task automatic chk_rst(input string p, input logic [AW-1:0] a,
                           input logic en, input logic bsy, input logic dn,
                           input logic er, input logic [CW-1:0] wc,
                           input logic wv, input logic [IW-1:0] wi,
                           input logic [DW-1:0] wdat,
                           input logic [ML*DW-1:0] bd);
        chk({p, " rst_addr"}, 64'(a), 64'(0));
        chk({p, " rst_rd_en"}, 64'(en), 64'(0));
        chk({p, " rst_busy"}, 64'(bsy), 64'(0));
        chk({p, " rst_done"}, 64'(dn), 64'(0));
        chk({p, " rst_err"}, 64'(er), 64'(0));
        chk({p, " rst_count"}, 64'(wc), 64'(0));
        chk({p, " rst_wvalid"}, 64'(wv), 64'(0));
        chk({p, " rst_widx"}, 64'(wi), 64'(0));
        chk({p, " rst_wdata"}, 64'(wdat), 64'(0));
        chk_buf({p, " rst_buf"}, bd, '0);
    endtask

    task automatic chk_rst_all();
        chk_rst("L1", bus1.rom_addr, bus1.rom_rd_en, busy1, done1, err1,
                wc1, wv1, widx1, wd1, buf1);
        chk_rst("L3", bus3.rom_addr, bus3.rom_rd_en, busy3, done3, err3,
                wc3, wv3, widx3, wd3, buf3);
    endtask

    // ab: abort cycle, s2: stray start cycle, rs: reset cycle (-1 = none)
    task automatic burst(input int b, input int len, input int ab,
                         input int s2, input int rs);
        int               lat, nreq, nw, dcyc, x, win;
        bit               bad, cut;
        logic [ML*DW-1:0] ev;
        win = 0;
        bad = (len == 0) || (len > ML);
        for (int d = 0; d < 2; d++) begin
            lat = (d == 0) ? 1 : 3;
            cut = 1'b0;
            x   = 0;
            if (rs > 0) begin
                cut = 1'b1;
                x   = rs;
            end else if (ab >= 1 && ab <= len + lat) begin
                cut = 1'b1;
                x   = ab;
            end
            if (bad) begin
                nreq = 0;
                nw   = 0;
                dcyc = 1;
            end else if (cut) begin
                nreq = (x < len) ? x : len;
                nw   = (x - 1 - lat < len) ? x - 1 - lat : len;
                if (nw < 0) nw = 0;
                dcyc = (rs > 0) ? 0 : x + 1;
            end else begin
                nreq = len;
                nw   = len;
                dcyc = len + lat + 1;
            end
            for (int i = 0; i < nreq; i++) begin
                if (d == 0) aq0.push_back(AW'((b + i) % 64));
                else        aq1.push_back(AW'((b + i) % 64));
            end
            for (int k = 0; k < nw; k++) begin
                word_t w;
                w.idx  = IW'(k);
                w.data = DW'(((b + k) % 64) ^ 'hA5);
                mbuf[d][k] = w.data;
                if (d == 0) wq0.push_back(w);
                else        wq1.push_back(w);
            end
            if (rs > 0)
                for (int k = 0; k < ML; k++) mbuf[d][k] = '0;
            t0[d]       = cyc;
            exp_done[d] = (dcyc > 0) ? cyc + dcyc : 0;
            exp_err[d]  = bad || (cut && rs <= 0);
            exp_cnt[d]  = nw;
            if (dcyc > win) win = dcyc;
            if (rs + 1 > win) win = rs + 1;
        end

        for (int k = 0; k <= win + 1; k++) begin
            start     = (k == 0) || (k == s2);
            base_addr = (k == 0) ? AW'(b) : AW'($urandom);
            length    = (k == 0) ? CW'(len) : CW'($urandom);
            abort     = (k == ab);
            reset     = (k == rs);
            if (rs > 0 && k == rs + 1) chk_rst_all();
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b0;

        chk("L1 reqs_left", 64'(aq0.size()), 64'(0));
        chk("L3 reqs_left", 64'(aq1.size()), 64'(0));
        chk("L1 words_left", 64'(wq0.size()), 64'(0));
        chk("L3 words_left", 64'(wq1.size()), 64'(0));
        aq0.delete();
        aq1.delete();
        wq0.delete();
        wq1.delete();
        for (int k = 0; k < ML; k++) ev[k*DW +: DW] = mbuf[0][k];
        chk_buf("L1 buf_data", buf1, ev);
        for (int k = 0; k < ML; k++) ev[k*DW +: DW] = mbuf[1][k];
        chk_buf("L3 buf_data", buf3, ev);
    endtask

    initial begin
        int b, len, ab, s2, r;
        for (int d = 0; d < 2; d++) begin
            exp_done[d] = 0;
            for (int k = 0; k < ML; k++) mbuf[d][k] = '0;
        end
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        length    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_rst_all();
        reset  = 1'b0;
        active = 1'b1;

        burst(0, 32, -1, -1, -1);
        burst(62, 4, -1, -1, -1);
        burst(5, 0, -1, -1, -1);
        burst(9, 33, -1, -1, -1);
        burst(10, 16, 5, -1, -1);
        burst(20, 12, -1, 4, -1);
        burst(33, 6, 0, -1, -1);
        burst(40, 8, -1, -1, 9);
        burst(1, 3, -1, -1, -1);

        for (int n = 0; n < 40; n++) begin
            b  = int'($urandom_range(0, 63));
            r  = int'($urandom_range(0, 19));
            if (r == 0)      len = 0;
            else if (r == 1) len = int'($urandom_range(33, 63));
            else             len = int'($urandom_range(1, 32));
            ab = -1;
            s2 = -1;
            r  = int'($urandom_range(0, 9));
            if (r < 3)
                ab = int'($urandom_range(1, len + 3));
            else if (r == 3)
                ab = 0;
            else if (r < 6 && len >= 1 && len <= ML)
                s2 = int'($urandom_range(1, len));
            burst(b, len, ab, s2, -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
